// File: rtl/or1k_wb_ext_arbiter.sv
// Round-robin arbiter from NODES tile Wishbone masters onto one shared external bus.
// Define OR1K_WB_ARB_TIMEOUT_EN to abort accesses whose strobe stalls for TIMEOUT_CYCLES cycles.
module or1k_wb_ext_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned NODES          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NODES*AW-1:0] wb_ext_adr_i,
    input  logic [NODES-1:0]    wb_ext_cyc_i,
    input  logic [NODES*DW-1:0] wb_ext_dat_i,
    input  logic [NODES*4-1:0]  wb_ext_sel_i,
    input  logic [NODES-1:0]    wb_ext_stb_i,
    input  logic [NODES-1:0]    wb_ext_we_i,
    input  logic [NODES-1:0]    wb_ext_cab_i,
    input  logic [NODES*3-1:0]  wb_ext_cti_i,
    input  logic [NODES*2-1:0]  wb_ext_bte_i,
    output logic [NODES-1:0]    wb_ext_ack_o,
    output logic [NODES-1:0]    wb_ext_rty_o,
    output logic [NODES-1:0]    wb_ext_err_o,
    output logic [NODES*DW-1:0] wb_ext_dat_o,
    output logic [AW-1:0]       m_adr_o,
    output logic [DW-1:0]       m_dat_o,
    output logic [3:0]          m_sel_o,
    output logic                m_cyc_o,
    output logic                m_stb_o,
    output logic                m_we_o,
    output logic                m_cab_o,
    output logic [2:0]          m_cti_o,
    output logic [1:0]          m_bte_o,
    input  logic                m_ack_i,
    input  logic                m_rty_i,
    input  logic                m_err_i,
    input  logic [DW-1:0]       m_dat_i
);

    localparam int unsigned GW = $clog2(NODES);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   next_grant;
    logic [GW-1:0]   grant_inc;
    logic            any_req;
    logic            busy;
    logic            cyc_raw;
    logic            stb_raw;
    logic            timeout;

    assign busy      = (state == StBusy);
    assign any_req   = |wb_ext_cyc_i;
    assign cyc_raw   = busy & wb_ext_cyc_i[grant];
    assign stb_raw   = busy & wb_ext_stb_i[grant];
    assign grant_inc = (grant == GW'(NODES - 1)) ? '0 : grant + 1'b1;

    // Walk backwards so the lowest offset from rr_ptr is the final (winning) assignment.
    always_comb begin
        next_grant = rr_ptr;
        for (int i = NODES - 1; i >= 0; i--) begin
            if (wb_ext_cyc_i[(int'(rr_ptr) + i) % NODES]) begin
                next_grant = GW'((int'(rr_ptr) + i) % NODES);
            end
        end
    end

`ifdef OR1K_WB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] to_cnt;
    logic          stall;

    assign stall   = cyc_raw & stb_raw & ~(m_ack_i | m_rty_i | m_err_i);
    assign timeout = stall & (to_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (stall && !timeout) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        grant <= next_grant;
                        state <= StBusy;
                    end
                end
                StBusy: begin
                    if (!wb_ext_cyc_i[grant] || timeout) begin
                        rr_ptr <= grant_inc;
                        state  <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        m_adr_o = '0;
        m_dat_o = '0;
        m_sel_o = '0;
        m_we_o  = 1'b0;
        m_cab_o = 1'b0;
        m_cti_o = '0;
        m_bte_o = '0;
        if (busy) begin
            m_adr_o = wb_ext_adr_i[grant*AW +: AW];
            m_dat_o = wb_ext_dat_i[grant*DW +: DW];
            m_sel_o = wb_ext_sel_i[grant*4 +: 4];
            m_we_o  = wb_ext_we_i[grant];
            m_cab_o = wb_ext_cab_i[grant];
            m_cti_o = wb_ext_cti_i[grant*3 +: 3];
            m_bte_o = wb_ext_bte_i[grant*2 +: 2];
        end
    end

    assign m_cyc_o = cyc_raw & ~timeout;
    assign m_stb_o = stb_raw & ~timeout;

    always_comb begin
        wb_ext_ack_o = '0;
        wb_ext_rty_o = '0;
        wb_ext_err_o = '0;
        for (int i = 0; i < NODES; i++) begin
            if (busy && grant == GW'(i)) begin
                wb_ext_ack_o[i] = m_ack_i;
                wb_ext_rty_o[i] = m_rty_i;
                wb_ext_err_o[i] = m_err_i | timeout;
            end
        end
    end

    assign wb_ext_dat_o = {NODES{m_dat_i}};

endmodule

// File: tb/tb_or1k_wb_ext_arbiter.sv
// Directed self-checking bench for or1k_wb_ext_arbiter (8 tiles, TIMEOUT_CYCLES=16).
// Exercises the timeout path when OR1K_WB_ARB_TIMEOUT_EN is defined, the stalled-hold path otherwise.
module tb_or1k_wb_ext_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned NODES = 8;
    localparam int unsigned TO    = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NODES*AW-1:0] adr = '0;
    logic [NODES-1:0]    cyc = '0;
    logic [NODES*DW-1:0] wdat = '0;
    logic [NODES*4-1:0]  sel = '0;
    logic [NODES-1:0]    stb = '0;
    logic [NODES-1:0]    we = '0;
    logic [NODES-1:0]    cab = '0;
    logic [NODES*3-1:0]  cti = '0;
    logic [NODES*2-1:0]  bte = '0;
    logic [NODES-1:0]    ack;
    logic [NODES-1:0]    rty;
    logic [NODES-1:0]    err;
    logic [NODES*DW-1:0] rdat;
    logic [AW-1:0]       m_adr;
    logic [DW-1:0]       m_dat;
    logic [3:0]          m_sel;
    logic                m_cyc;
    logic                m_stb;
    logic                m_we;
    logic                m_cab;
    logic [2:0]          m_cti;
    logic [1:0]          m_bte;
    logic                m_ack = 1'b0;
    logic                m_rty = 1'b0;
    logic                m_err = 1'b0;
    logic [DW-1:0]       m_rdat = '0;

    int checks = 0;
    int errors = 0;
    int burst_acks;

    or1k_wb_ext_arbiter #(
        .AW(AW), .DW(DW), .NODES(NODES), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_ext_adr_i(adr), .wb_ext_cyc_i(cyc), .wb_ext_dat_i(wdat), .wb_ext_sel_i(sel),
        .wb_ext_stb_i(stb), .wb_ext_we_i(we), .wb_ext_cab_i(cab), .wb_ext_cti_i(cti),
        .wb_ext_bte_i(bte), .wb_ext_ack_o(ack), .wb_ext_rty_o(rty), .wb_ext_err_o(err),
        .wb_ext_dat_o(rdat),
        .m_adr_o(m_adr), .m_dat_o(m_dat), .m_sel_o(m_sel), .m_cyc_o(m_cyc), .m_stb_o(m_stb),
        .m_we_o(m_we), .m_cab_o(m_cab), .m_cti_o(m_cti), .m_bte_o(m_bte),
        .m_ack_i(m_ack), .m_rty_i(m_rty), .m_err_i(m_err), .m_dat_i(m_rdat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic on);
        cyc[k] = on;
        stb[k] = on;
    endtask

    function automatic logic [AW-1:0] tile_adr(input int k);
        return 32'h0100 * (k + 1);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        cyc   = '0;
        stb   = '0;
        cti   = '0;
        m_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Called just after the edge on which tile k became owner; one beat, release, dead cycle.
    task automatic serve(input int k, input logic [DW-1:0] d);
        m_ack  = 1'b1;
        m_rdat = d;
        #4;
        check("srv_adr", 64'(m_adr), 64'(tile_adr(k)));
        check("srv_ack", 64'(ack), 64'd1 << k);
        check("srv_we", 64'(m_we), 64'(k % 2));
        check("srv_dat", 64'(rdat[k*DW +: DW]), 64'(d));
        step();
        m_ack = 1'b0;
        set_req(k, 1'b0);
        #4;
        check("srv_drop", 64'(m_cyc), 64'd0);
        step();
        #4;
        check("srv_gap", 64'({m_cyc, m_stb}), 64'd0);
        step();
    endtask

    initial begin
        for (int k = 0; k < NODES; k++) begin
            adr[k*AW +: AW]  = tile_adr(k);
            wdat[k*DW +: DW] = 32'hD000_0000 + k;
            sel[k*4 +: 4]    = 4'hF;
            we[k]            = k[0];
        end
        adr[3*AW +: AW] = 32'h1000;

        // Reset and idle
        do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_cyc", 64'(m_cyc), 64'd0);
        check("rst_resp", 64'({ack, rty, err}), 64'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #4;
            check("idle_cyc", 64'(m_cyc), 64'd0);
            check("idle_resp", 64'({ack, rty, err}), 64'd0);
            check("idle_adr", 64'(m_adr), 64'd0);
            step();
        end

        // Single read from tile 3
        set_req(3, 1'b1);
        #4;
        check("rd_nogrant", 64'(m_cyc), 64'd0);
        step();
        #4;
        check("rd_adr", 64'(m_adr), 64'h1000);
        check("rd_cyc", 64'(m_cyc), 64'd1);
        check("rd_ack_wait", 64'(ack), 64'd0);
        step();
        m_ack  = 1'b1;
        m_rdat = 32'hCAFE_F00D;
        #4;
        check("rd_ack", 64'(ack), 64'h08);
        check("rd_dat3", 64'(rdat[3*DW +: DW]), 64'hCAFE_F00D);
        check("rd_dat0", 64'(rdat[0 +: DW]), 64'hCAFE_F00D);
        step();
        m_ack = 1'b0;
        set_req(3, 1'b0);
        #4;
        check("rd_ack_end", 64'(ack), 64'd0);
        step();

        // Round-robin: 0, 2, 5 from a fresh rr_ptr
        do_reset();
        set_req(0, 1'b1);
        set_req(2, 1'b1);
        set_req(5, 1'b1);
        #4;
        check("rr_nogrant", 64'(m_cyc), 64'd0);
        step();
        serve(0, 32'h1111_0000);
        serve(2, 32'h2222_0000);
        serve(5, 32'h5555_0000);
        #4;
        check("rr_done", 64'(m_cyc), 64'd0);
        step();

        // Burst hold: tile 1 owns the bus for 4 beats while tile 0 waits
        cti[1*3 +: 3] = 3'b010;
        set_req(1, 1'b1);
        step();
        set_req(0, 1'b1);
        burst_acks = 0;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                stb[1] = 1'b0;
                #4;
                check("bst_gap_cyc", 64'(m_cyc), 64'd1);
                check("bst_gap_stb", 64'(m_stb), 64'd0);
                check("bst_gap_adr", 64'(m_adr), 64'(tile_adr(1)));
                step();
                stb[1] = 1'b1;
            end
            if (b == 3) cti[1*3 +: 3] = 3'b111;
            m_ack = 1'b1;
            #4;
            check("bst_ack", 64'(ack), 64'h02);
            check("bst_cti", 64'(m_cti), (b == 3) ? 64'd7 : 64'd2);
            burst_acks += int'(ack[1]);
            step();
            m_ack = 1'b0;
        end
        check("bst_count", 64'(burst_acks), 64'd4);
        set_req(1, 1'b0);
        cti = '0;
        #4;
        check("bst_release", 64'(m_cyc), 64'd0);
        step();
        #4;
        check("bst_dead", 64'(m_cyc), 64'd0);
        step();
        serve(0, 32'h0000_AAAA);

        // Reset during beat 2 of a tile-2 burst (rr_ptr is 1, so tile 2 beats tile 0)
        cti[2*3 +: 3] = 3'b010;
        set_req(2, 1'b1);
        set_req(0, 1'b1);
        step();
        m_ack = 1'b1;
        #4;
        check("mrst_beat1", 64'(ack), 64'h04);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_cyc", 64'(m_cyc), 64'd0);
        check("mrst_ack", 64'(ack), 64'd0);
        m_ack = 1'b0;
        step();
        rst_n = 1'b1;
        #4;
        check("mrst_idle", 64'(m_cyc), 64'd0);
        step();
        #4;
        check("mrst_grant0", 64'(m_adr), 64'(tile_adr(0)));
        check("mrst_cyc0", 64'(m_cyc), 64'd1);
        cyc = '0;
        stb = '0;
        cti = '0;
        step();
        step();

`ifdef OR1K_WB_ARB_TIMEOUT_EN
        // Stalled slave on tile 6: error on stb cycle 16, then tile 1 is served
        do_reset();
        set_req(6, 1'b1);
        step();
        set_req(1, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            #4;
            if (c < 16) begin
                check("to_wait_err", 64'(err), 64'd0);
                check("to_wait_cyc", 64'(m_cyc), 64'd1);
            end else begin
                check("to_err", 64'(err), 64'h40);
                check("to_cyc", 64'({m_cyc, m_stb}), 64'd0);
            end
            step();
        end
        m_ack = 1'b1;
        set_req(6, 1'b0);
        #4;
        check("to_late_ack", 64'(ack), 64'd0);
        check("to_err_once", 64'(err), 64'd0);
        check("to_idle", 64'(m_cyc), 64'd0);
        step();
        m_ack = 1'b0;
        #4;
        check("to_next", 64'(m_adr), 64'(tile_adr(1)));
        set_req(1, 1'b0);
        step();
`else
        // Stalled slave on tile 6 keeps the bus indefinitely
        do_reset();
        set_req(6, 1'b1);
        step();
        set_req(1, 1'b1);
        repeat (40) step();
        #4;
        check("stall_cyc", 64'(m_cyc), 64'd1);
        check("stall_adr", 64'(m_adr), 64'(tile_adr(6)));
        check("stall_err", 64'(err), 64'd0);
        cyc = '0;
        stb = '0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
